cmplx_mult_driver: RTL

Initiator-side companion of the complex multiplier control path. Buffers operand quadruples written by the host, issues them one at a time over the multiplier's op_val/op_ready handshake, accepts each result over res_val/res_ready, and buffers results for the host to read. Sits between host/testbench logic and one multiplier instance.

---
 rtl/cmplx_mult_driver.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cmplx_mult_driver.sv
// Host-side driver for one complex multiplier: a command FIFO feeds operands over op_val/op_ready,
// and a result FIFO collects res_val/res_ready results for the host, one operation in flight.
module cmplx_mult_driver #(
    parameter int DATA_WIDTH = 8,
    parameter int RES_WIDTH  = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  sw_rst,
    input  logic                  cmd_wr,
    input  logic [DATA_WIDTH-1:0] cmd_ar,
    input  logic [DATA_WIDTH-1:0] cmd_ai,
    input  logic [DATA_WIDTH-1:0] cmd_br,
    input  logic [DATA_WIDTH-1:0] cmd_bi,
    output logic                  cmd_full,
    output logic                  cmd_ovf,
    output logic                  op_val,
    input  logic                  op_ready,
    output logic [DATA_WIDTH-1:0] op_ar,
    output logic [DATA_WIDTH-1:0] op_ai,
    output logic [DATA_WIDTH-1:0] op_br,
    output logic [DATA_WIDTH-1:0] op_bi,
    input  logic                  res_val,
    output logic                  res_ready,
    input  logic [RES_WIDTH-1:0]  res_re,
    input  logic [RES_WIDTH-1:0]  res_im,
    input  logic                  rd_en,
    output logic [RES_WIDTH-1:0]  rd_re,
    output logic [RES_WIDTH-1:0]  rd_im,
    output logic                  rd_empty,
    output logic [7:0]            issued_cnt,
    output logic [7:0]            done_cnt,
    output logic                  busy
);

    // state    | meaning
    // IDLE     | nothing to issue, waiting for a command
    // ISSUE    | presenting command FIFO head to the multiplier
    // WAIT_RES | operands accepted, waiting for the result
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RES = 2'd2
    } state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam int CMD_W = 4 * DATA_WIDTH;
    localparam int RES_W = 2 * RES_WIDTH;

    state_t state;

    logic [CMD_W-1:0] cmd_mem [FIFO_DEPTH];
    logic [AW-1:0]    cmd_wp;
    logic [AW-1:0]    cmd_rp;
    logic [CW-1:0]    cmd_count;
    logic [CW-1:0]    cmd_count_nxt;

    logic [RES_W-1:0] res_mem [FIFO_DEPTH];
    logic [AW-1:0]    res_wp;
    logic [AW-1:0]    res_rp;
    logic [CW-1:0]    res_count;
    logic [CW-1:0]    res_count_nxt;

    logic op_fire;
    logic res_fire;
    logic cmd_push;
    logic cmd_pop;
    logic res_push;
    logic res_pop;

    assign op_fire  = op_val & op_ready;
    assign res_fire = res_val & res_ready;
    assign cmd_push = cmd_wr & ~cmd_full;
    assign cmd_pop  = op_fire;
    assign res_push = res_fire;
    assign res_pop  = rd_en & ~rd_empty;

    assign cmd_count_nxt = cmd_count + CW'(cmd_push) - CW'(cmd_pop);
    assign res_count_nxt = res_count + CW'(res_push) - CW'(res_pop);

    assign cmd_full = (cmd_count == DEPTH_C);
    assign rd_empty = (res_count == '0);
    assign busy     = (state != IDLE) || (cmd_count != '0);

    assign {op_ar, op_ai, op_br, op_bi} = cmd_mem[cmd_rp];
    assign {rd_re, rd_im}               = res_mem[res_rp];

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                cmd_mem[i] <= '0;
            end
            cmd_wp    <= '0;
            cmd_rp    <= '0;
            cmd_count <= '0;
            cmd_ovf   <= 1'b0;
        end else begin
            if (cmd_push) begin
                cmd_mem[cmd_wp] <= {cmd_ar, cmd_ai, cmd_br, cmd_bi};
                cmd_wp          <= cmd_wp + AW'(1);
            end
            if (cmd_pop) begin
                cmd_rp <= cmd_rp + AW'(1);
            end
            if (cmd_wr && cmd_full) begin
                cmd_ovf <= 1'b1;
            end
            cmd_count <= cmd_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                res_mem[i] <= '0;
            end
            res_wp    <= '0;
            res_rp    <= '0;
            res_count <= '0;
        end else begin
            if (res_push) begin
                res_mem[res_wp] <= {res_re, res_im};
                res_wp          <= res_wp + AW'(1);
            end
            if (res_pop) begin
                res_rp <= res_rp + AW'(1);
            end
            res_count <= res_count_nxt;
        end
    end

    // res_ready is registered from next-cycle occupancy, so it can never accept into a full FIFO
    always_ff @(posedge clk) begin
        if (sw_rst) begin
            state      <= IDLE;
            op_val     <= 1'b0;
            res_ready  <= 1'b0;
            issued_cnt <= '0;
            done_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    res_ready <= 1'b0;
                    if (cmd_count != '0) begin
                        state  <= ISSUE;
                        op_val <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (op_fire) begin
                        state      <= WAIT_RES;
                        op_val     <= 1'b0;
                        res_ready  <= (res_count_nxt != DEPTH_C);
                        issued_cnt <= issued_cnt + 8'd1;
                    end
                end
                WAIT_RES: begin
                    if (res_fire) begin
                        done_cnt  <= done_cnt + 8'd1;
                        res_ready <= 1'b0;
                        if (cmd_count_nxt != '0) begin
                            state  <= ISSUE;
                            op_val <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        res_ready <= (res_count_nxt != DEPTH_C);
                    end
                end
                default: begin
                    state     <= IDLE;
                    op_val    <= 1'b0;
                    res_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
